// File: rtl/gc_pkg.sv
// Shared types and constants for the GameCube controller poll sequencer.
package gc_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StRx,
        StDone,
        StErr
    } gc_state_e;

    // Standard poll command; bit 0 is replaced by the rumble request.
    localparam logic [23:0] GC_CMD_POLL = 24'h400302;

    localparam int unsigned GC_CMD_BITS   = 24;
    localparam int unsigned GC_REPLY_BITS = 64;

    // Cell timing in units of 1 us.
    localparam int unsigned MULT_ONE_LOW  = 1;  // low phase of a '1' or stop cell
    localparam int unsigned MULT_SAMPLE   = 2;  // reply sample point after a falling edge
    localparam int unsigned MULT_ZERO_LOW = 3;  // low phase of a '0' cell
    localparam int unsigned MULT_CELL     = 4;  // full cell length

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the open-drain controller line plus falling-edge detect.
module gc_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the pad value through the synchronizer and keep last cycle's value.
    always_comb begin
        meta_d = data_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Line idles high on the pull-up, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/gc_poll_ctrl.sv
// Periodic poll scheduler and transaction sequencer for the GameCube controller line.
module gc_poll_ctrl
    import gc_pkg::*;
#(
    parameter int unsigned US_CYCLES      = 10,
    parameter int unsigned POLL_CYCLES    = 60000,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        enable,
    input  logic        rumble,
    input  logic        data_in,
    output logic        data_oe,
    output logic [63:0] buttons,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    localparam int unsigned CellW = $clog2(MULT_CELL * US_CYCLES);
    localparam int unsigned SampW = $clog2(MULT_SAMPLE * US_CYCLES);
    localparam int unsigned PollW = $clog2(POLL_CYCLES);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES);

    localparam logic [CellW-1:0] CellLast = CellW'(MULT_CELL * US_CYCLES - 1);
    localparam logic [CellW-1:0] OneLow   = CellW'(MULT_ONE_LOW * US_CYCLES);
    localparam logic [CellW-1:0] ZeroLow  = CellW'(MULT_ZERO_LOW * US_CYCLES);
    localparam logic [SampW-1:0] SampLast = SampW'(MULT_SAMPLE * US_CYCLES - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_CYCLES - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       StopCell = 5'(GC_CMD_BITS);
    localparam logic [5:0]       BitLast  = 6'(GC_REPLY_BITS - 1);

    gc_state_e         state_q, state_d;
    logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [CellW-1:0]  cell_cnt_q, cell_cnt_d;
    logic [4:0]        cell_idx_q, cell_idx_d;
    logic [23:0]       cmd_q, cmd_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic [SampW-1:0]  samp_cnt_q, samp_cnt_d;
    logic              samp_run_q, samp_run_d;
    logic [5:0]        bit_idx_q, bit_idx_d;
    logic [63:0]       shift_q, shift_d;
    logic [63:0]       buttons_q, buttons_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              data_oe_q, data_oe_d;

    logic              line_sync;
    logic              line_fall;
    logic              tx_bit;
    logic [CellW-1:0]  low_len;

    gc_line_sync u_line_sync (
        .clk_i  (PCLK),
        .rst_ni (PRESETN),
        .data_i (data_in),
        .sync_o (line_sync),
        .fall_o (line_fall)
    );

    // Poll scheduling, TX cell sequencing, RX sampling and result publication.
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        cell_cnt_d = cell_cnt_q;
        cell_idx_d = cell_idx_q;
        cmd_d      = cmd_q;
        to_cnt_d   = to_cnt_q;
        samp_cnt_d = samp_cnt_q;
        samp_run_d = samp_run_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        // The poll counter keeps running through a transaction so the period is
        // measured from TX start; it saturates if the transaction overruns.
        if (state_q != StIdle && poll_cnt_q != PollLast) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!enable) begin
                    poll_cnt_d = '0;
                end else if (poll_cnt_q == PollLast) begin
                    poll_cnt_d = '0;
                    state_d    = StTx;
                    cell_cnt_d = '0;
                    cell_idx_d = '0;
                    cmd_d      = {GC_CMD_POLL[23:1], rumble};
                end else begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                end
            end

            StTx: begin
                if (cell_cnt_q == CellLast) begin
                    cell_cnt_d = '0;
                    if (cell_idx_q == StopCell) begin
                        state_d    = StRx;
                        to_cnt_d   = '0;
                        samp_cnt_d = '0;
                        samp_run_d = 1'b0;
                        bit_idx_d  = '0;
                    end else begin
                        cell_idx_d = cell_idx_q + 1'b1;
                    end
                end else begin
                    cell_cnt_d = cell_cnt_q + 1'b1;
                end
            end

            StRx: begin
                if (line_fall) begin
                    // A new edge before the previous bit was sampled is a glitch.
                    if (samp_run_q) begin
                        state_d = StErr;
                    end else begin
                        samp_run_d = 1'b1;
                        samp_cnt_d = '0;
                        to_cnt_d   = '0;
                    end
                end else begin
                    if (samp_run_q) begin
                        if (samp_cnt_q == SampLast) begin
                            samp_run_d = 1'b0;
                            shift_d    = {shift_q[62:0], line_sync};
                            if (bit_idx_q == BitLast) begin
                                state_d = StDone;
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + 1'b1;
                        end
                    end
                    if (to_cnt_q == ToLast) begin
                        state_d = StErr;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            StDone: begin
                valid_d   = 1'b1;
                buttons_d = shift_q;
                state_d   = StIdle;
            end

            StErr: begin
                error_d = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Line drive follows the next cell position so data_oe is a clean flop output.
        if (cell_idx_d >= StopCell) begin
            tx_bit = 1'b1;
        end else begin
            tx_bit = cmd_d[5'd23 - cell_idx_d];
        end
        low_len   = tx_bit ? OneLow : ZeroLow;
        data_oe_d = (state_d == StTx) && (cell_cnt_d < low_len);
        busy_d    = (state_d != StIdle) || valid_d || error_d;
    end

    // State and registered outputs; reset releases the line immediately.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= StIdle;
            poll_cnt_q <= '0;
            cell_cnt_q <= '0;
            cell_idx_q <= '0;
            cmd_q      <= '0;
            to_cnt_q   <= '0;
            samp_cnt_q <= '0;
            samp_run_q <= 1'b0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            cell_cnt_q <= cell_cnt_d;
            cell_idx_q <= cell_idx_d;
            cmd_q      <= cmd_d;
            to_cnt_q   <= to_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            samp_run_q <= samp_run_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign data_oe = data_oe_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;
    assign error   = error_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gc_poll_ctrl.sv
// Directed bench for gc_poll_ctrl with a simple controller model and event scoreboard.
`timescale 1ns/1ps
module tb_gc_poll_ctrl;

    localparam int unsigned US     = 10;
    localparam int unsigned POLL   = 5000;
    localparam int unsigned TMO    = 1000;
    localparam int unsigned TX_LEN = 25 * 4 * US;

    localparam logic [63:0] D1 = 64'h0080_8080_8080_1F1F;
    localparam logic [63:0] D2 = 64'hA5C3_0F96_1234_FEDC;
    localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;

    logic        PCLK;
    logic        PRESETN;
    logic        enable;
    logic        rumble;
    logic        data_in;
    logic        data_oe;
    logic [63:0] buttons;
    logic        valid;
    logic        error;
    logic        busy;
    logic        dev_low;

    typedef struct packed {
        logic        is_err;
        logic [63:0] btn;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   ev_cnt;
    int   ev_cyc;

    // Open-drain line: either side pulls it low.
    assign data_in = ~(data_oe | dev_low);

    gc_poll_ctrl #(
        .US_CYCLES      (US),
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .enable  (enable),
        .rumble  (rumble),
        .data_in (data_in),
        .data_oe (data_oe),
        .buttons (buttons),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    initial begin
        PCLK = 1'b0;
        forever #50 PCLK = ~PCLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge PCLK);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge PCLK);
    endtask

    task automatic wait_tx_start(output int t);
        for (int i = 0; i < 2 * POLL && !data_oe; i++) @(negedge PCLK);
        chk("tx_start_seen", {63'b0, data_oe}, 64'd1);
        chk("busy_at_tx_start", {63'b0, busy}, 64'd1);
        t = cyc;
    endtask

    // Classify each 4 us cell by its low-phase length: 1 us -> '1', 3 us -> '0'.
    task automatic decode_tx(input int t, output logic [24:0] bits);
        int lowc;
        for (int k = 0; k < 25; k++) begin
            lowc = 0;
            for (int j = 0; j < 4 * US; j++) begin
                wait_until(t + 4 * US * k + j);
                if (data_oe) lowc++;
            end
            if (lowc == US) bits[24-k] = 1'b1;
            else if (lowc == 3 * US) bits[24-k] = 1'b0;
            else bits[24-k] = 1'bx;
        end
    endtask

    task automatic send_reply(input logic [63:0] d, input int nbits, input int drop_at);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) enable = 1'b0;
            b = d[63-i];
            dev_low = 1'b1;
            repeat (b ? US : 3 * US) @(negedge PCLK);
            dev_low = 1'b0;
            repeat (b ? 3 * US : US) @(negedge PCLK);
        end
        if (nbits == 64) begin
            dev_low = 1'b1;
            repeat (US) @(negedge PCLK);
            dev_low = 1'b0;
            repeat (3 * US) @(negedge PCLK);
        end
    endtask

    task automatic wait_event(input int n0);
        for (int i = 0; i < 4000 && ev_cnt == n0; i++) @(negedge PCLK);
        chk("event_seen", {63'b0, ev_cnt != n0}, 64'd1);
    endtask

    // Output monitor: pops the scoreboard on every valid/error pulse.
    initial begin
        exp_t e;
        logic post_chk;
        post_chk = 1'b0;
        ev_cnt   = 0;
        ev_cyc   = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESETN) begin
                post_chk = 1'b0;
            end else begin
                if (post_chk) begin
                    chk("pulse_one_cycle", {62'b0, valid, error}, 64'd0);
                    chk("busy_after_pulse", {63'b0, busy}, 64'd0);
                    post_chk = 1'b0;
                end
                if (valid || error) begin
                    ev_cnt++;
                    ev_cyc   = cyc;
                    post_chk = 1'b1;
                    chk("busy_during_pulse", {63'b0, busy}, 64'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {62'b0, valid, error}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", {62'b0, valid, error}, {62'b0, ~e.is_err, e.is_err});
                        chk("event_buttons", buttons, e.btn);
                    end
                end
            end
        end
    end

    initial begin
        int          t_s;
        int          t_prev;
        int          rel;
        int          n0;
        logic [24:0] dec;
        logic        oe_seen;

        vectors     = 0;
        miscompares = 0;
        PRESETN     = 1'b0;
        enable      = 1'b0;
        rumble      = 1'b0;
        dev_low     = 1'b0;

        // Reset state.
        repeat (3) @(negedge PCLK);
        chk("rst_data_oe", {63'b0, data_oe}, 64'd0);
        chk("rst_buttons", buttons, 64'd0);
        chk("rst_valid", {63'b0, valid}, 64'd0);
        chk("rst_error", {63'b0, error}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        PRESETN = 1'b1;
        enable  = 1'b1;
        rel     = cyc;

        // Basic poll and good reply.
        wait_tx_start(t_s);
        chk("first_poll_at_period", 64'(t_s - rel), 64'(POLL));
        decode_tx(t_s, dec);
        chk("tx_bits_poll", {39'b0, dec}, {39'b0, 24'h400302, 1'b1});
        exp_q.push_back('{is_err: 1'b0, btn: D1});
        n0 = ev_cnt;
        repeat (20) @(negedge PCLK);
        send_reply(D1, 64, -1);
        wait_event(n0);
        t_prev = t_s;

        // Silent controller: timeout after TX end, buttons held.
        wait_tx_start(t_s);
        chk("poll_spacing_2", 64'(t_s - t_prev), 64'(POLL));
        exp_q.push_back('{is_err: 1'b1, btn: D1});
        n0 = ev_cnt;
        decode_tx(t_s, dec);
        wait_event(n0);
        // RX starts TX_LEN after TX start; ERR after TMO idle cycles, pulse one later.
        chk("timeout_timing", 64'(ev_cyc - t_s), 64'(TX_LEN + TMO + 1));
        t_prev = t_s;

        // Short reply of 40 bits then silence.
        wait_tx_start(t_s);
        chk("poll_spacing_3", 64'(t_s - t_prev), 64'(POLL));
        exp_q.push_back('{is_err: 1'b1, btn: D1});
        n0 = ev_cnt;
        decode_tx(t_s, dec);
        repeat (20) @(negedge PCLK);
        send_reply(D2, 40, -1);
        wait_event(n0);
        rumble = 1'b1;
        t_prev = t_s;

        // Rumble poll with a good reply.
        wait_tx_start(t_s);
        chk("poll_spacing_4", 64'(t_s - t_prev), 64'(POLL));
        decode_tx(t_s, dec);
        chk("tx_bits_rumble", {39'b0, dec}, {39'b0, 24'h400303, 1'b1});
        rumble = 1'b0;
        exp_q.push_back('{is_err: 1'b0, btn: D2});
        n0 = ev_cnt;
        repeat (20) @(negedge PCLK);
        send_reply(D2, 64, -1);
        wait_event(n0);
        t_prev = t_s;

        // Glitch: second falling edge 0.5 us after a reply bit edge.
        wait_tx_start(t_s);
        chk("poll_spacing_5", 64'(t_s - t_prev), 64'(POLL));
        exp_q.push_back('{is_err: 1'b1, btn: D2});
        n0 = ev_cnt;
        decode_tx(t_s, dec);
        repeat (20) @(negedge PCLK);
        send_reply(D1, 3, -1);
        dev_low = 1'b1;
        repeat (2) @(negedge PCLK);
        dev_low = 1'b0;
        repeat (US / 2 - 2) @(negedge PCLK);
        dev_low = 1'b1;
        repeat (3 * US) @(negedge PCLK);
        dev_low = 1'b0;
        wait_event(n0);
        t_prev = t_s;

        // Reset asserted during the 10th TX cell (a '0' cell, so the line is low).
        wait_tx_start(t_s);
        chk("poll_spacing_6", 64'(t_s - t_prev), 64'(POLL));
        wait_until(t_s + 9 * 4 * US + 5);
        chk("cell10_driving", {63'b0, data_oe}, 64'd1);
        PRESETN = 1'b0;
        #1;
        chk("mid_rst_data_oe", {63'b0, data_oe}, 64'd0);
        chk("mid_rst_buttons", buttons, 64'd0);
        chk("mid_rst_valid", {63'b0, valid}, 64'd0);
        chk("mid_rst_error", {63'b0, error}, 64'd0);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        rel     = cyc;

        // Enable dropped mid-RX: transaction completes, then polling stops.
        wait_tx_start(t_s);
        chk("poll_after_reset", 64'(t_s - rel), 64'(POLL));
        decode_tx(t_s, dec);
        chk("tx_bits_after_reset", {39'b0, dec}, {39'b0, 24'h400302, 1'b1});
        exp_q.push_back('{is_err: 1'b0, btn: D3});
        n0 = ev_cnt;
        repeat (20) @(negedge PCLK);
        send_reply(D3, 64, 10);
        wait_event(n0);
        oe_seen = 1'b0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge PCLK);
            oe_seen = oe_seen | data_oe | busy;
        end
        chk("no_poll_when_disabled", {63'b0, oe_seen}, 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
